// File: rtl/fetch_pc_unit.sv
// Program-counter / fetch-control stage: sequences IDLE -> RUN -> DONE and drives current_pc into instruction memory.
// Optional address range check against IMEM_DEPTH is enabled by defining FETCH_PC_BOUND_CHECK_EN (adds pc_fault).
module fetch_pc_unit #(
    parameter int PC_W       = 32,
    parameter int START_ADDR = 0,
    parameter int IMEM_DEPTH = 4096
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    input  logic            halt,
    input  logic            branch_taken,
    input  logic            branch_relative,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] current_pc,
    output logic            fetch_valid,
    output logic            busy,
`ifdef FETCH_PC_BOUND_CHECK_EN
    output logic            pc_fault,
`endif
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] LP_START = PC_W'(START_ADDR);

    if (IMEM_DEPTH < 1) begin : g_bad_depth
        $error("fetch_pc_unit: IMEM_DEPTH must be positive");
    end

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_next_pc;
    logic [PC_W-1:0] w_branch_pc;
    logic            w_oob;

    // Relative targets are two's-complement offsets; plain add wraps mod 2^PC_W.
    assign w_branch_pc = branch_relative ? (r_pc + branch_target) : branch_target;
    assign w_next_pc   = branch_taken ? w_branch_pc : (r_pc + 1'b1);

`ifdef FETCH_PC_BOUND_CHECK_EN
    localparam logic [PC_W:0] LP_DEPTH = (PC_W+1)'(IMEM_DEPTH);
    logic r_fault;

    assign w_oob = ({1'b0, w_next_pc} >= LP_DEPTH);
`else
    assign w_oob = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pc    <= LP_START;
`ifdef FETCH_PC_BOUND_CHECK_EN
            r_fault <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_pc    <= LP_START;
`ifdef FETCH_PC_BOUND_CHECK_EN
                        r_fault <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    if (stall) begin
                        r_state <= S_RUN;
                    end else if (halt) begin
                        r_state <= S_DONE;
                    end else if (w_oob) begin
                        // Out-of-range fetch: stop with PC still at the last legal address.
                        r_state <= S_DONE;
`ifdef FETCH_PC_BOUND_CHECK_EN
                        r_fault <= 1'b1;
`endif
                    end else begin
                        r_pc <= w_next_pc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pc    <= LP_START;
                end
            endcase
        end
    end

    assign current_pc  = r_pc;
    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    // A stalled cycle re-presents the same address, so it is not a new fetch.
    assign fetch_valid = (r_state == S_RUN) && !stall;
`ifdef FETCH_PC_BOUND_CHECK_EN
    assign pc_fault    = r_fault;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Table-driven bench for fetch_pc_unit with a scoreboard queue of expected post-edge outputs.
// Define FETCH_PC_BOUND_CHECK_EN for both bench and RTL to exercise the range-check section.
module tb_fetch_pc_unit;

    localparam int PC_W = 32;

    logic            clk;
    logic            reset;
    logic            start, stall, halt, branch_taken, branch_relative;
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] current_pc;
    logic            fetch_valid, busy, done;
`ifdef FETCH_PC_BOUND_CHECK_EN
    logic            pc_fault;
`endif

    fetch_pc_unit #(.PC_W(PC_W), .START_ADDR(0), .IMEM_DEPTH(4096)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .stall           (stall),
        .halt            (halt),
        .branch_taken    (branch_taken),
        .branch_relative (branch_relative),
        .branch_target   (branch_target),
        .current_pc      (current_pc),
        .fetch_valid     (fetch_valid),
        .busy            (busy),
`ifdef FETCH_PC_BOUND_CHECK_EN
        .pc_fault        (pc_fault),
`endif
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic            start, stall, halt, br, rel;
        logic [PC_W-1:0] target;
        logic [PC_W-1:0] exp_pc;
        logic            exp_busy, exp_done, exp_fv;
    } vec_t;

    typedef struct {
        string           name;
        logic [PC_W-1:0] pc;
        logic            busy, done, fv;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input string nm, input logic s, input logic st, input logic h,
                       input logic b, input logic r, input logic [PC_W-1:0] t,
                       input logic [PC_W-1:0] pc, input logic bz, input logic dn, input logic fv);
        vec_t v;
        v.name = nm; v.start = s; v.stall = st; v.halt = h; v.br = b; v.rel = r;
        v.target = t; v.exp_pc = pc; v.exp_busy = bz; v.exp_done = dn; v.exp_fv = fv;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [PC_W-1:0] act, input logic [PC_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 0; stall = 0; halt = 0; branch_taken = 0; branch_relative = 0; branch_target = '0;
    endtask

    task automatic compare_outputs(input exp_t e);
        chk({e.name, ".pc"},   current_pc,  e.pc);
        chk({e.name, ".busy"}, PC_W'(busy), PC_W'(e.busy));
        chk({e.name, ".done"}, PC_W'(done), PC_W'(e.done));
        chk({e.name, ".fv"},   PC_W'(fetch_valid), PC_W'(e.fv));
    endtask

    // Drive each vector just after an edge, expect the result after the following edge.
    task automatic run_vectors();
        exp_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start; stall = vecs[i].stall; halt = vecs[i].halt;
            branch_taken = vecs[i].br; branch_relative = vecs[i].rel; branch_target = vecs[i].target;
            e.name = vecs[i].name; e.pc = vecs[i].exp_pc;
            e.busy = vecs[i].exp_busy; e.done = vecs[i].exp_done; e.fv = vecs[i].exp_fv;
            sb.push_back(e);
            @(posedge clk); #1;
            compare_outputs(sb.pop_front());
        end
        vecs.delete();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        #12;
        chk("rst.pc",   current_pc, '0);
        chk("rst.busy", PC_W'(busy), '0);
        chk("rst.done", PC_W'(done), '0);
        chk("rst.fv",   PC_W'(fetch_valid), '0);
`ifdef FETCH_PC_BOUND_CHECK_EN
        chk("rst.fault", PC_W'(pc_fault), '0);
`endif
        @(posedge clk); #1;
        reset = 1;

        //   name         st  stl h  br rel target        pc            busy done fv
        add("idle_hold",  0,  0,  1, 1, 0,  32'h40,       32'h0,        0,   0,   0);
        add("start",      1,  0,  0, 0, 0,  32'h0,        32'h0,        1,   0,   1);
        add("inc1",       0,  0,  0, 0, 0,  32'h0,        32'h1,        1,   0,   1);
        add("inc2",       1,  0,  0, 0, 0,  32'h0,        32'h2,        1,   0,   1);
        add("inc3",       0,  0,  0, 0, 0,  32'h0,        32'h3,        1,   0,   1);
        add("inc4",       0,  0,  0, 0, 0,  32'h0,        32'h4,        1,   0,   1);
        add("abs10",      0,  0,  0, 1, 0,  32'd10,       32'd10,       1,   0,   1);
        add("stall1",     0,  1,  1, 1, 0,  32'h99,       32'd10,       1,   0,   0);
        add("stall2",     0,  1,  0, 1, 1,  32'h5,        32'd10,       1,   0,   0);
        add("stall3",     0,  1,  0, 0, 0,  32'h0,        32'd10,       1,   0,   0);
        add("abs20",      0,  0,  0, 1, 0,  32'h20,       32'h20,       1,   0,   1);
        add("rel_m3",     0,  0,  0, 1, 1,  32'hFFFFFFFD, 32'h1D,       1,   0,   1);
        add("rel_p5",     0,  0,  0, 1, 1,  32'h5,        32'h22,       1,   0,   1);
        add("abs0",       0,  0,  0, 1, 0,  32'h0,        32'h0,        1,   0,   1);
`ifndef FETCH_PC_BOUND_CHECK_EN
        add("rel_wrap",   0,  0,  0, 1, 1,  32'hFFFFFFFF, 32'hFFFFFFFF, 1,   0,   1);
        add("inc_wrap",   0,  0,  0, 0, 0,  32'h0,        32'h0,        1,   0,   1);
`endif
        add("abs7",       0,  0,  0, 1, 0,  32'h7,        32'h7,        1,   0,   1);
        add("halt_br",    0,  0,  1, 1, 0,  32'h30,       32'h7,        0,   1,   0);
        add("done_hold",  0,  0,  0, 1, 0,  32'h30,       32'h7,        0,   1,   0);
        add("restart",    1,  0,  0, 0, 0,  32'h0,        32'h0,        1,   0,   1);
        add("inc_r1",     0,  0,  0, 0, 0,  32'h0,        32'h1,        1,   0,   1);
        add("abs55",      0,  0,  0, 1, 0,  32'h55,       32'h55,       1,   0,   1);
        run_vectors();

        // Asynchronous reset between edges while running at 0x55.
        #3;
        reset = 0;
        #1;
        chk("async.pc",   current_pc, '0);
        chk("async.busy", PC_W'(busy), '0);
        chk("async.done", PC_W'(done), '0);
        chk("async.fv",   PC_W'(fetch_valid), '0);
        @(posedge clk); #1;
        reset = 1;
        add("post_rst1",  0,  0,  0, 0, 0,  32'h0,        32'h0,        0,   0,   0);
        add("post_rst2",  0,  0,  0, 1, 0,  32'h44,       32'h0,        0,   0,   0);
        add("start_halt", 1,  0,  1, 0, 0,  32'h0,        32'h0,        1,   0,   1);
        add("inc_s1",     0,  0,  0, 0, 0,  32'h0,        32'h1,        1,   0,   1);
        run_vectors();

`ifdef FETCH_PC_BOUND_CHECK_EN
        add("abs4095",    0,  0,  0, 1, 0,  32'd4095,     32'd4095,     1,   0,   1);
        run_vectors();
        chk("pre.fault", PC_W'(pc_fault), '0);
        add("inc_oob",    0,  0,  0, 0, 0,  32'h0,        32'd4095,     0,   1,   0);
        run_vectors();
        chk("oob.fault", PC_W'(pc_fault), 32'h1);
        add("restart_f",  1,  0,  0, 0, 0,  32'h0,        32'h0,        1,   0,   1);
        run_vectors();
        chk("clr.fault", PC_W'(pc_fault), '0);
`endif

        if (sb.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
